// File: rtl/dmx_pkg.sv
// Shared types and default timing for the DMX512 receive path.
// Timing defaults assume a 12 MHz system clock.
package dmx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BREAK = 2'd1,
      MAB   = 2'd2,
      SLOTS = 2'd3
   } dmx_state_e;

   localparam int DMX_MAX_SLOTS       = 512;
   localparam int DMX_BREAK_MIN_CYC   = 1056;   // 88 us
   localparam int DMX_MAB_MIN_CYC     = 96;     // 8 us
   localparam int DMX_IDLE_TO_CYC     = 12000;  // 1 ms
   localparam int DMX_CNT_W           = 16;
   localparam int DMX_IDX_W           = 10;

endpackage

// File: rtl/dmx_dur_counter.sv
// Saturating duration counter: clear has priority, then counts while enabled
// and holds at all-ones.
module dmx_dur_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dmx_rx_frame_ctrl.sv
// DMX512 receive frame sequencer: times BREAK/MAB, arms the UART and numbers slots.
// Optional DMX_START_CODE_FILTER_EN suppresses data slots of non-zero start-code frames.
module dmx_rx_frame_ctrl
   import dmx_pkg::*;
#(
   parameter int BREAK_MIN_CYC = DMX_BREAK_MIN_CYC,
   parameter int MAB_MIN_CYC   = DMX_MAB_MIN_CYC,
   parameter int IDLE_TO_CYC   = DMX_IDLE_TO_CYC,
   parameter int MAX_SLOTS     = DMX_MAX_SLOTS,
   parameter int CNT_W         = DMX_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_level,
   input  logic                 rx_fall,
   input  logic                 rx_rise,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   input  logic                 framing_err,
   output logic                 uart_en,
   output logic                 frame_start,
   output logic                 slot_valid,
   output logic [DMX_IDX_W-1:0] slot_index,
   output logic [7:0]           slot_data,
   output logic                 start_code_ok,
   output logic                 frame_done,
   output logic [DMX_IDX_W-1:0] frame_len,
   output logic                 timing_err
);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_BREAK = BREAK;
   localparam logic [1:0] ST_MAB   = MAB;
   localparam logic [1:0] ST_SLOTS = SLOTS;

   localparam logic [CNT_W-1:0]     BREAK_MIN = CNT_W'(BREAK_MIN_CYC);
   localparam logic [CNT_W-1:0]     MAB_MIN   = CNT_W'(MAB_MIN_CYC);
   localparam logic [CNT_W-1:0]     IDLE_TO   = CNT_W'(IDLE_TO_CYC);
   localparam logic [DMX_IDX_W-1:0] SLOT_END  = DMX_IDX_W'(MAX_SLOTS + 1);

   logic [1:0]           state;
   logic [CNT_W-1:0]     low_cnt;
   logic [CNT_W-1:0]     hi_cnt;
   logic [DMX_IDX_W-1:0] slot_cnt;
   logic [DMX_IDX_W-1:0] data_len;
   logic                 slot_pass;

   // A simultaneous fall and rise is illegal; the fall wins everywhere.
   dmx_dur_counter #(.W(CNT_W)) u_low_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (rx_fall),
      .en    (~rx_level),
      .cnt   (low_cnt)
   );

   dmx_dur_counter #(.W(CNT_W)) u_hi_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (rx_rise & ~rx_fall),
      .en    (rx_level),
      .cnt   (hi_cnt)
   );

`ifdef DMX_START_CODE_FILTER_EN
   assign slot_pass = (slot_cnt == '0) || start_code_ok;
   assign data_len  = ((slot_cnt == '0) || !start_code_ok) ? '0 : slot_cnt - 1'b1;
`else
   assign slot_pass = 1'b1;
   assign data_len  = (slot_cnt == '0) ? '0 : slot_cnt - 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         slot_cnt      <= '0;
         uart_en       <= 1'b0;
         frame_start   <= 1'b0;
         slot_valid    <= 1'b0;
         slot_index    <= '0;
         slot_data     <= '0;
         start_code_ok <= 1'b0;
         frame_done    <= 1'b0;
         frame_len     <= '0;
         timing_err    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         slot_valid  <= 1'b0;
         frame_done  <= 1'b0;
         timing_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_fall) state <= ST_BREAK;
            end
            ST_BREAK: begin
               if (rx_rise && !rx_fall) state <= (low_cnt >= BREAK_MIN) ? ST_MAB : ST_IDLE;
            end
            ST_MAB: begin
               if (rx_fall) begin
                  if (hi_cnt >= MAB_MIN) begin
                     state         <= ST_SLOTS;
                     frame_start   <= 1'b1;
                     slot_cnt      <= '0;
                     start_code_ok <= 1'b0;
                  end else begin
                     // The short-MAB fall may itself be the start of a new BREAK.
                     state      <= ST_BREAK;
                     timing_err <= 1'b1;
                     uart_en    <= 1'b0;
                  end
               end else if (hi_cnt >= MAB_MIN) begin
                  uart_en <= 1'b1;
               end
            end
            ST_SLOTS: begin
               if (slot_cnt == SLOT_END) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b1;
                  frame_len  <= data_len;
                  uart_en    <= 1'b0;
               end else if (byte_valid && framing_err) begin
                  // A framing error is the next BREAK already in progress; low_cnt keeps running.
                  state      <= ST_BREAK;
                  frame_done <= 1'b1;
                  frame_len  <= data_len;
                  uart_en    <= 1'b0;
               end else if (byte_valid) begin
                  slot_valid <= slot_pass;
                  slot_index <= slot_cnt;
                  slot_data  <= byte_data;
                  slot_cnt   <= slot_cnt + 1'b1;
                  if (slot_cnt == '0) start_code_ok <= (byte_data == 8'h00);
               end else if (hi_cnt >= IDLE_TO) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b1;
                  frame_len  <= data_len;
                  uart_en    <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmx_rx_frame_ctrl.sv
// Directed self-checking bench for dmx_rx_frame_ctrl; honours DMX_START_CODE_FILTER_EN.
module tb_dmx_rx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_level;
   logic       rx_fall;
   logic       rx_rise;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       framing_err;
   logic       uart_en;
   logic       frame_start;
   logic       slot_valid;
   logic [9:0] slot_index;
   logic [7:0] slot_data;
   logic       start_code_ok;
   logic       frame_done;
   logic [9:0] frame_len;
   logic       timing_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Pulse monitor state
   int         n_fs, n_te, n_fd, n_sv, seq_err, data_err, exp_idx;
   logic [9:0] last_len;
   logic [7:0] exp_byte [0:512];

   dmx_rx_frame_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_level      (rx_level),
      .rx_fall       (rx_fall),
      .rx_rise       (rx_rise),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .framing_err   (framing_err),
      .uart_en       (uart_en),
      .frame_start   (frame_start),
      .slot_valid    (slot_valid),
      .slot_index    (slot_index),
      .slot_data     (slot_data),
      .start_code_ok (start_code_ok),
      .frame_done    (frame_done),
      .frame_len     (frame_len),
      .timing_err    (timing_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_start) begin
         n_fs++;
         exp_idx = 0;
      end
      if (timing_err) n_te++;
      if (frame_done) begin
         n_fd++;
         last_len = frame_len;
      end
      if (slot_valid) begin
         n_sv++;
         if (slot_index !== 10'(exp_idx)) seq_err++;
         if (slot_data !== exp_byte[slot_index]) data_err++;
         exp_idx++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      n_fs = 0; n_te = 0; n_fd = 0; n_sv = 0;
      seq_err = 0; data_err = 0; last_len = '0;
   endtask

   task automatic go_low(input int n);
      rx_level = 1'b0;
      rx_fall  = 1'b1;
      cyc();
      rx_fall  = 1'b0;
      repeat (n - 1) cyc();
   endtask

   task automatic go_high(input int n);
      rx_level = 1'b1;
      rx_rise  = 1'b1;
      cyc();
      rx_rise  = 1'b0;
      repeat (n - 1) cyc();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fe);
      byte_valid  = 1'b1;
      byte_data   = b;
      framing_err = fe;
      cyc();
      byte_valid  = 1'b0;
      framing_err = 1'b0;
      cyc();
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) send_byte(exp_byte[i], 1'b0);
   endtask

   // BREAK 1100, MAB 100, start-bit fall, then line back high for the bytes
   task automatic open_frame();
      go_low(1100);
      go_high(100);
      go_low(3);
      go_high(5);
   endtask

   initial begin
      rst_n = 1'b0; rx_level = 1'b1; rx_fall = 1'b0; rx_rise = 1'b0;
      byte_valid = 1'b0; byte_data = 8'h00; framing_err = 1'b0;
      exp_idx = 0;
      for (int i = 0; i <= 512; i++) exp_byte[i] = 8'(i * 3);
      exp_byte[0] = 8'h00;
      clr_mon();
      repeat (3) cyc();
      check("rst_uart_en", uart_en, 0);
      check("rst_slot_index", slot_index, 0);
      check("rst_frame_len", frame_len, 0);
      check("rst_start_code_ok", start_code_ok, 0);
      rst_n = 1'b1;
      repeat (3) cyc();

      // Full 512-slot frame
      go_low(1100);
      go_high(100);
      check("mab_uart_armed", uart_en, 1);
      go_low(3);
      go_high(5);
      send_bytes(513);
      repeat (3) cyc();
      check("full_frame_start", n_fs, 1);
      check("full_slot_count", n_sv, 513);
      check("full_index_seq", seq_err, 0);
      check("full_slot_data", data_err, 0);
      check("full_start_code_ok", start_code_ok, 1);
      check("full_frame_done", n_fd, 1);
      check("full_frame_len", last_len, 512);
      check("full_uart_off", uart_en, 0);

      // Short BREAK is dropped silently
      clr_mon();
      go_low(500);
      go_high(200);
      check("short_brk_no_start", n_fs, 0);
      check("short_brk_no_terr", n_te, 0);
      check("short_brk_uart", uart_en, 0);

      // Short MAB, then a valid BREAK/MAB straight from the error
      clr_mon();
      go_low(1100);
      go_high(50);
      go_low(1100);
      check("short_mab_terr", n_te, 1);
      check("short_mab_uart", uart_en, 0);
      check("short_mab_no_start", n_fs, 0);
      go_high(100);
      go_low(3);
      check("after_terr_start", n_fs, 1);

      // 24-byte frame ended by line-idle timeout
      for (int i = 0; i < 24; i++) exp_byte[i] = 8'(i + 5);
      exp_byte[0] = 8'h00;
      go_high(5);
      send_bytes(24);
      check("to_not_yet_done", n_fd, 0);
      repeat (12010) cyc();
      check("to_frame_done", n_fd, 1);
      check("to_frame_len", last_len, 23);
      check("to_slot_count", n_sv, 24);
      check("to_slot_data", data_err, 0);
      check("to_uart_off", uart_en, 0);

      // 10 data bytes, then a framing error that is the next BREAK
      clr_mon();
      for (int i = 0; i < 11; i++) exp_byte[i] = 8'(8'hA0 + i);
      exp_byte[0] = 8'h00;
      open_frame();
      send_bytes(11);
      rx_level = 1'b0;
      rx_fall  = 1'b1;
      cyc();
      rx_fall  = 1'b0;
      repeat (20) cyc();
      send_byte(8'h00, 1'b1);
      repeat (1077) cyc();
      check("fe_frame_done", n_fd, 1);
      check("fe_frame_len", last_len, 10);
      check("fe_slot_count", n_sv, 11);
      check("fe_uart_off", uart_en, 0);
      clr_mon();
      go_high(100);
      go_low(3);
      check("fe_restart", n_fs, 1);

      // Non-zero start code 0x17 with 3 data bytes
      exp_byte[0] = 8'h17; exp_byte[1] = 8'hAA; exp_byte[2] = 8'hBB; exp_byte[3] = 8'hCC;
      go_high(5);
      send_bytes(4);
      check("sc17_start_code_ok", start_code_ok, 0);
      repeat (12010) cyc();
      check("sc17_frame_done", n_fd, 1);
      check("sc17_index_seq", seq_err, 0);
      check("sc17_slot_data", data_err, 0);
`ifdef DMX_START_CODE_FILTER_EN
      check("sc17_slot_count", n_sv, 1);
      check("sc17_frame_len", last_len, 0);
`else
      check("sc17_slot_count", n_sv, 4);
      check("sc17_frame_len", last_len, 3);
`endif

      // Reset in the middle of a frame
      clr_mon();
      exp_byte[0] = 8'h00; exp_byte[1] = 8'h11; exp_byte[2] = 8'h22;
      open_frame();
      send_bytes(3);
      check("mid_uart_on", uart_en, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_uart", uart_en, 0);
      check("mid_rst_index", slot_index, 0);
      cyc();
      rst_n = 1'b1;
      repeat (12100) cyc();
      check("mid_rst_no_done", n_fd, 0);
      check("mid_rst_uart_idle", uart_en, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
